// File: rtl/reg_window_ctrl.sv
// -----------------------------------------------------------------------------
// reg_window_ctrl
//
// Upstream control stage of the SPARC register file.
//   - Holds the current window pointer (CWP) and window invalid mask (WIM).
//   - Executes SAVE / RESTORE and flags window overflow / underflow.
//   - Decodes the 5-bit architectural destination register into physical write
//     strobes for the global block (BE, RE7..RE0) and the windowed block
//     (WinIdx + WinWE). The decode is registered and acts as the writeback
//     pipeline register in front of the register blocks (1-cycle latency).
//
// Optional feature macro: REG_WINDOW_TRAP_CNT_EN
//   defined   : TrapCnt is a 16-bit saturating count of OvfTrap/UnfTrap pulses
//   undefined : no counter logic, TrapCnt tied to 16'h0000
//
// Parameters
//   NWINDOWS  number of register windows (2..32)
//   CWPW      CWP width, >= clog2(NWINDOWS)
//   PW        windowed physical index width, >= clog2(NWINDOWS*16)
//
// Ports
//   Clk       in   1         clock, rising edge
//   Rst       in   1         synchronous reset, active-high
//   WrEn      in   1         architectural register write request
//   RC        in   5         architectural destination register r0..r31
//   Save      in   1         SAVE request (pulse)
//   Restore   in   1         RESTORE request (pulse)
//   CwpLd     in   1         direct CWP load (WRPSR)
//   CwpIn     in   CWPW      CWP load value
//   WimLd     in   1         WIM load (WRWIM)
//   WimIn     in   NWINDOWS  WIM load value
//   BE        out  1         global block write enable
//   RE        out  8         one-hot global register select
//   WinWE     out  1         windowed block write enable
//   WinIdx    out  PW        windowed physical register index
//   Cwp       out  CWPW      current window pointer
//   Wim       out  NWINDOWS  window invalid mask
//   OvfTrap   out  1         window overflow, one-cycle pulse
//   UnfTrap   out  1         window underflow, one-cycle pulse
//   TrapCnt   out  16        trap counter (see macro above)
// -----------------------------------------------------------------------------
module reg_window_ctrl #(
   parameter int NWINDOWS = 8,
   parameter int CWPW     = 3,
   parameter int PW       = 7
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                WrEn,
   input  logic [4:0]          RC,
   input  logic                Save,
   input  logic                Restore,
   input  logic                CwpLd,
   input  logic [CWPW-1:0]     CwpIn,
   input  logic                WimLd,
   input  logic [NWINDOWS-1:0] WimIn,
   output logic                BE,
   output logic [7:0]          RE,
   output logic                WinWE,
   output logic [PW-1:0]       WinIdx,
   output logic [CWPW-1:0]     Cwp,
   output logic [NWINDOWS-1:0] Wim,
   output logic                OvfTrap,
   output logic                UnfTrap,
   output logic [15:0]         TrapCnt
);

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // Reduce an arbitrary CWP value into 0..NWINDOWS-1.
   function automatic logic [CWPW-1:0] cwp_mod(input logic [CWPW-1:0] v);
      logic [31:0] t;
      t = 32'(v) % 32'(NWINDOWS);
      return t[CWPW-1:0];
   endfunction

   // Select WIM bit for window w; the loop avoids an index wider than the mask.
   function automatic logic wim_bit(input logic [NWINDOWS-1:0] m,
                                    input logic [CWPW-1:0]     w);
      logic b;
      b = 1'b0;
      for (int k = 0; k < NWINDOWS; k++) begin
         if (32'(w) == 32'(k)) b = m[k];
      end
      return b;
   endfunction

   // Physical windowed index: window * 16 + offset within the 16-entry slice.
   function automatic logic [PW-1:0] win_index(input logic [CWPW-1:0] w,
                                               input logic [3:0]      off);
      logic [31:0] t;
      t = 32'(w) * 32'd16 + 32'(off);
      return t[PW-1:0];
   endfunction

   // Saturating 16-bit increment.
   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [CWPW-1:0]     cwp_q,    cwp_d;
   logic [NWINDOWS-1:0] wim_q,    wim_d;
   logic                be_q,     be_d;
   logic [7:0]          re_q,     re_d;
   logic                winwe_q,  winwe_d;
   logic [PW-1:0]       winidx_q, winidx_d;
   logic                ovf_q,    ovf_d;
   logic                unf_q,    unf_d;

   // Neighbouring windows, with wrap at both ends.
   logic [CWPW-1:0] cwp_dec;   // SAVE target
   logic [CWPW-1:0] cwp_inc;   // RESTORE target, also home of the ins

   always_comb begin
      cwp_dec = (cwp_q == '0) ? CWPW'(NWINDOWS - 1) : cwp_q - CWPW'(1);
      cwp_inc = (cwp_q == CWPW'(NWINDOWS - 1)) ? '0 : cwp_q + CWPW'(1);
   end

   // ---------------------------------------------------------------------------
   // Write address decode (uses the pre-update CWP)
   // ---------------------------------------------------------------------------
   always_comb begin
      be_d     = 1'b0;
      re_d     = 8'h00;
      winwe_d  = 1'b0;
      winidx_d = winidx_q;   // index only moves when a windowed write occurs
      if (WrEn) begin
         case (RC[4:3])
            2'b00: begin
               // g0 is hardwired zero: RC=0 produces no strobe at all.
               if (RC[2:0] != 3'd0) begin
                  be_d = 1'b1;
                  re_d = 8'h01 << RC[2:0];
               end
            end
            2'b01: begin   // outs r8..r15
               winwe_d  = 1'b1;
               winidx_d = win_index(cwp_q, {1'b0, RC[2:0]});
            end
            2'b10: begin   // locals r16..r23
               winwe_d  = 1'b1;
               winidx_d = win_index(cwp_q, {1'b1, RC[2:0]});
            end
            default: begin // ins r24..r31 alias the outs of window CWP+1
               winwe_d  = 1'b1;
               winidx_d = win_index(cwp_inc, {1'b0, RC[2:0]});
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Window pointer / WIM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      cwp_d = cwp_q;
      wim_d = WimLd ? WimIn : wim_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (CwpLd) begin
         // Direct load bypasses the trap check entirely.
         cwp_d = cwp_mod(CwpIn);
      end else if (Save && !Restore) begin
         // Trap check uses the WIM value before any same-edge WimLd.
         if (wim_bit(wim_q, cwp_dec)) ovf_d = 1'b1;
         else                         cwp_d = cwp_dec;
      end else if (Restore && !Save) begin
         if (wim_bit(wim_q, cwp_inc)) unf_d = 1'b1;
         else                         cwp_d = cwp_inc;
      end
      // Save and Restore together cancel: no move, no trap.
   end

   // ---------------------------------------------------------------------------
   // Stage boundary: writeback pipeline register and window state
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cwp_q    <= '0;
         wim_q    <= '0;
         be_q     <= 1'b0;
         re_q     <= 8'h00;
         winwe_q  <= 1'b0;
         winidx_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         cwp_q    <= cwp_d;
         wim_q    <= wim_d;
         be_q     <= be_d;
         re_q     <= re_d;
         winwe_q  <= winwe_d;
         winidx_q <= winidx_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

`ifdef REG_WINDOW_TRAP_CNT_EN
   // Counter advances on the same edge that registers the trap pulse, so the
   // new count is visible together with OvfTrap/UnfTrap.
   logic [15:0] trapcnt_q, trapcnt_d;

   always_comb begin
      trapcnt_d = trapcnt_q;
      if (ovf_d || unf_d) trapcnt_d = sat_inc(trapcnt_q);
   end

   always_ff @(posedge Clk) begin
      if (Rst) trapcnt_q <= 16'h0000;
      else     trapcnt_q <= trapcnt_d;
   end

   assign TrapCnt = trapcnt_q;
`else
   assign TrapCnt = 16'h0000;
`endif

   assign BE      = be_q;
   assign RE      = re_q;
   assign WinWE   = winwe_q;
   assign WinIdx  = winidx_q;
   assign Cwp     = cwp_q;
   assign Wim     = wim_q;
   assign OvfTrap = ovf_q;
   assign UnfTrap = unf_q;

endmodule
